// File: rtl/leb128_decoder.sv
// leb128_decoder: streaming uLEB/sLEB128 immediate decoder, one byte per cycle.
// Emits a 64-bit extended value, byte count and malformed-encoding flag per number.
`default_nettype none

module leb128_decoder #(
  parameter bit USE_64B = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_signed,
  input  logic        in_is64,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [3:0]  out_len,
  output logic        out_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        signed_q, signed_d;
  logic        is64_q, is64_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] value_q, value_d;
  logic [3:0]  len_q, len_d;
  logic        error_q, error_d;

  logic        first;
  logic        cur_signed;
  logic        cur_is64;
  logic [3:0]  cur_cnt;
  logic [6:0]  shift;
  logic [6:0]  total;
  logic [63:0] acc_new;
  logic [63:0] fill_mask;
  logic [63:0] value_raw;
  logic [63:0] value_ext;
  logic        is_last;
  logic        final_bad;
  logic        fin_err;

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign out_value = value_q;
  assign out_len   = len_q;
  assign out_error = error_q;

  always_comb begin
    first      = (state_q == S_IDLE);
    cur_signed = first ? in_signed : signed_q;
    cur_is64   = USE_64B && (first ? in_is64 : is64_q);
    cur_cnt    = first ? 4'd1 : cnt_q + 4'd1;
    shift      = (7'(cur_cnt) - 7'd1) * 7'd7;
    total      = 7'(cur_cnt) * 7'd7;
    // The 10th group lands at shift 63, so only its bit 0 survives the truncation.
    acc_new    = (first ? 64'd0 : acc_q) | ({57'd0, in_byte[6:0]} << shift);
    is_last    = (cur_cnt == (cur_is64 ? 4'd10 : 4'd5));

    // Unused high bits of the final byte must agree with the value's range.
    case ({cur_is64, cur_signed})
      2'b00:   final_bad = (in_byte[6:4] != 3'b000);
      2'b01:   final_bad = !((in_byte[6:3] == 4'h0) || (in_byte[6:3] == 4'hF));
      2'b10:   final_bad = (in_byte[6:1] != 6'd0);
      default: final_bad = !((in_byte[6:0] == 7'h00) || (in_byte[6:0] == 7'h7F));
    endcase

    fill_mask = (total < 7'd64) ? ~((64'd1 << total) - 64'd1) : 64'd0;
    value_raw = (cur_signed && in_byte[6]) ? (acc_new | fill_mask) : acc_new;
    if (cur_is64)
      value_ext = value_raw;
    else if (cur_signed)
      value_ext = {{32{value_raw[31]}}, value_raw[31:0]};
    else
      value_ext = {32'd0, value_raw[31:0]};

    fin_err  = in_byte[7] || (is_last && final_bad);

    state_d  = state_q;
    signed_d = signed_q;
    is64_d   = is64_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    len_d    = len_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (in_valid) begin
          signed_d = cur_signed;
          is64_d   = cur_is64;
          acc_d    = acc_new;
          cnt_d    = cur_cnt;
          if (in_byte[7] && !is_last) begin
            state_d = S_ACCUM;
          end else begin
            value_d = fin_err ? 64'd0 : value_ext;
            len_d   = cur_cnt;
            error_d = fin_err;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      signed_q <= 1'b0;
      is64_q   <= 1'b0;
      acc_q    <= 64'd0;
      cnt_q    <= 4'd0;
      value_q  <= 64'd0;
      len_q    <= 4'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      is64_q   <= is64_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      len_q    <= len_d;
      error_q  <= error_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_leb128_decoder.sv
// tb_leb128_decoder: directed and randomized checks of leb128_decoder
// against an arithmetic LEB128 reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_leb128_decoder;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_signed;
  logic        in_is64;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leb128_decoder #(.USE_64B(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_signed (in_signed),
    .in_is64   (in_is64),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_len   (out_len),
    .out_error (out_error)
  );

  // Value = sum of 7-bit groups, sign applied by subtracting 2^(7n),
  // then a plain range check against the target integer type.
  function automatic void ref_decode(input byte_q_t b, input bit s, input bit w,
                                     output logic [63:0] v, output logic [3:0] len,
                                     output bit err);
    logic [127:0] acc;
    logic [127:0] off;
    int n;
    int bits;
    n    = b.size();
    bits = w ? 64 : 32;
    acc  = '0;
    err  = 1'b0;
    for (int i = 0; i < n; i++)
      acc = acc | ({121'd0, b[i][6:0]} << (7 * i));
    if (b[n-1][7]) err = 1'b1;
    if (s && b[n-1][6]) acc = acc - (128'd1 << (7 * n));
    off = s ? acc + (128'd1 << (bits - 1)) : acc;
    if (off >= (128'd1 << bits)) err = 1'b1;
    v   = err ? 64'd0 : acc[63:0];
    len = 4'(n);
  endfunction

  function automatic byte_q_t gen(input bit s, input bit w);
    byte_q_t b;
    int nmax;
    int len;
    nmax = w ? 10 : 5;
    len  = ($urandom_range(0, 3) == 0) ? nmax : int'($urandom_range(1, nmax));
    for (int i = 0; i < len - 1; i++)
      b.push_back(8'h80 | 8'($urandom_range(0, 127)));
    if (len < nmax)
      b.push_back(8'($urandom_range(0, 127)));
    else if ($urandom_range(0, 2) == 0)
      b.push_back(8'($urandom_range(0, 255)));
    else begin
      case ({w, s})
        2'b00:   b.push_back(8'($urandom_range(0, 15)));
        2'b01:   b.push_back(($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7))
                                                         : 8'h78 | 8'($urandom_range(0, 7)));
        2'b10:   b.push_back(8'($urandom_range(0, 1)));
        default: b.push_back(($urandom_range(0, 1) != 0) ? 8'h00 : 8'h7F);
      endcase
    end
    return b;
  endfunction

  // Drives one number (optionally with idle gaps), captures the result, then completes the handshake.
  task automatic run_number(input byte_q_t b, input bit s, input bit w, input bit gaps,
                            output logic [63:0] v, output logic [3:0] len,
                            output logic err, output int lat);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid  = 1'b0;
          in_byte   = 8'($urandom);
          in_signed = 1'($urandom);
          in_is64   = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid  = 1'b1;
      in_byte   = b[i];
      in_signed = (i == 0) ? s : 1'($urandom);
      in_is64   = (i == 0) ? w : 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    v   = out_value;
    len = out_len;
    err = out_error;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_signed = 1'b0;
    in_is64 = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_value !== 64'd0) begin errors++; $display("FAIL reset_out_value got %h want 0", out_value); end
    checks++; if (out_len !== 4'd0) begin errors++; $display("FAIL reset_out_len got %0d want 0", out_len); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL reset_out_error got %0b want 0", out_error); end
  endtask

  task automatic test_directed();
    byte_q_t b;
    logic [63:0] v;
    logic [3:0] len;
    logic err;
    int lat;
    b = '{8'hE5, 8'h8E, 8'h26};
    run_number(b, 1'b0, 1'b0, 1'b0, v, len, err, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL u32_latency got %0d want 0", lat); end
    checks++; if (v !== 64'h98765 || len !== 4'd3 || err !== 1'b0) begin errors++;
      $display("FAIL u32_624485 got %h/%0d/%0b want 98765/3/0", v, len, err); end

    b = '{8'hC0, 8'hBB, 8'h78};
    run_number(b, 1'b1, 1'b0, 1'b0, v, len, err, lat);
    checks++; if (v !== 64'hFFFF_FFFF_FFFE_1DC0 || len !== 4'd3 || err !== 1'b0) begin errors++;
      $display("FAIL s32_neg got %h/%0d/%0b want fffffffffffe1dc0/3/0", v, len, err); end

    b = '{8'h7F};
    run_number(b, 1'b1, 1'b1, 1'b0, v, len, err, lat);
    checks++; if (v !== 64'hFFFF_FFFF_FFFF_FFFF || len !== 4'd1 || err !== 1'b0) begin errors++;
      $display("FAIL s64_minus1 got %h/%0d/%0b want ffffffffffffffff/1/0", v, len, err); end

    b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
    run_number(b, 1'b0, 1'b1, 1'b0, v, len, err, lat);
    checks++; if (v !== 64'h8000_0000_0000_0000 || len !== 4'd10 || err !== 1'b0) begin errors++;
      $display("FAIL u64_bit63 got %h/%0d/%0b want 8000000000000000/10/0", v, len, err); end

    b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h10};
    run_number(b, 1'b0, 1'b0, 1'b0, v, len, err, lat);
    checks++; if (v !== 64'd0 || len !== 4'd5 || err !== 1'b1) begin errors++;
      $display("FAIL u32_range_err got %h/%0d/%0b want 0/5/1", v, len, err); end

    b = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_number(b, 1'b0, 1'b0, 1'b0, v, len, err, lat);
    checks++; if (v !== 64'd0 || len !== 4'd5 || err !== 1'b1) begin errors++;
      $display("FAIL u32_overlong_err got %h/%0d/%0b want 0/5/1", v, len, err); end

    b = '{8'h03};
    run_number(b, 1'b0, 1'b0, 1'b0, v, len, err, lat);
    checks++; if (v !== 64'd3 || len !== 4'd1 || err !== 1'b0) begin errors++;
      $display("FAIL after_err got %h/%0d/%0b want 3/1/0", v, len, err); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_byte = 8'h2A; in_signed = 1'b0; in_is64 = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1 || out_value !== 64'd42 || in_ready !== 1'b0) begin errors++;
        $display("FAIL hold_cycle%0d got valid=%0b value=%0d ready=%0b want 1/42/0", c, out_valid, out_value, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL hold_release got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    byte_q_t b;
    logic [63:0] v;
    logic [3:0] len;
    logic err;
    int lat;
    in_signed = 1'b0; in_is64 = 1'b0;
    in_valid = 1'b1; in_byte = 8'hE5;
    @(posedge clk); #1;
    in_byte = 8'h8E;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || out_value !== 64'd0 || out_len !== 4'd0 || out_error !== 1'b0) begin errors++;
      $display("FAIL async_reset got valid=%0b value=%h len=%0d err=%0b want all 0", out_valid, out_value, out_len, out_error); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %0b want 1", in_ready); end
    b = '{8'h05};
    run_number(b, 1'b0, 1'b0, 1'b0, v, len, err, lat);
    checks++; if (v !== 64'd5 || len !== 4'd1 || err !== 1'b0) begin errors++;
      $display("FAIL reset_mid_next got %h/%0d/%0b want 5/1/0", v, len, err); end
  endtask

  task automatic test_random();
    byte_q_t b;
    logic [63:0] v, ev;
    logic [3:0] len, el;
    logic err;
    bit ee, s, w;
    int lat;
    for (int k = 0; k < 300; k++) begin
      s = 1'($urandom);
      w = 1'($urandom);
      b = gen(s, w);
      ref_decode(b, s, w, ev, el, ee);
      run_number(b, s, w, 1'($urandom), v, len, err, lat);
      checks++; if (v !== ev || len !== el || err !== ee) begin errors++;
        $display("FAIL random%0d s=%0b w=%0b n=%0d got %h/%0d/%0b want %h/%0d/%0b", k, s, w, b.size(), v, len, err, ev, el, ee); end
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t b, stream;
    bit bs[$], bw[$], ee_q[$];
    logic [63:0] ev_q[$];
    logic [3:0] el_q[$];
    logic [63:0] ev;
    logic [3:0] el;
    bit ee, s, w, rdy;
    int total, cycles, nums;
    nums = 20;
    for (int k = 0; k < nums; k++) begin
      s = 1'($urandom);
      w = 1'($urandom);
      b = gen(s, w);
      ref_decode(b, s, w, ev, el, ee);
      ev_q.push_back(ev); el_q.push_back(el); ee_q.push_back(ee);
      foreach (b[i]) begin stream.push_back(b[i]); bs.push_back(s); bw.push_back(w); end
    end
    total = stream.size();
    out_ready = 1'b1;
    cycles = 0;
    while (ev_q.size() > 0 && cycles < 2000) begin
      if (stream.size() > 0) begin
        in_valid = 1'b1; in_byte = stream[0]; in_signed = bs[0]; in_is64 = bw[0];
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready;
      @(posedge clk); cycles++; #1;
      if (rdy && in_valid && stream.size() > 0) begin
        void'(stream.pop_front()); void'(bs.pop_front()); void'(bw.pop_front());
      end
      if (out_valid) begin
        checks++; if (out_value !== ev_q[0] || out_len !== el_q[0] || out_error !== ee_q[0]) begin errors++;
          $display("FAIL b2b_num%0d got %h/%0d/%0b want %h/%0d/%0b", nums - ev_q.size(), out_value, out_len, out_error, ev_q[0], el_q[0], ee_q[0]); end
        void'(ev_q.pop_front()); void'(el_q.pop_front()); void'(ee_q.pop_front());
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (ev_q.size() !== 0) begin errors++;
      $display("FAIL b2b_timeout got %0d pending want 0", ev_q.size()); end
    checks++; if (cycles !== total + nums - 1) begin errors++;
      $display("FAIL b2b_throughput got %0d cycles want %0d", cycles, total + nums - 1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/leb128_decoder.md
# leb128_decoder

Streaming LEB128 immediate decoder in the instruction-fetch path, directly upstream of `cpu` immediate consumers (`i32.const`, `i64.const`, branch depths, local indices). Consumes one code byte per cycle from the fetch byte stream and emits one decoded, width-extended immediate per number with a byte count so the fetch pointer can advance. Detects malformed encodings (overlong and out-of-range final byte) per the WebAssembly binary rules.

## Interface
- `USE_64B`, 1, enables 64-bit decoding; when 0, `in_is64` is ignored and every number decodes as 32-bit.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  decoder accepts a byte this cycle.
- `in_byte`  in  8  next code byte.
- `in_signed`  in  1  mode, sampled only on the first byte of a number: 1 = sLEB, 0 = uLEB.
- `in_is64`  in  1  mode, sampled only on the first byte: 1 = 64-bit, 0 = 32-bit.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_value`  out  64  decoded value, extended to 64 bits.
- `out_len`  out  4  bytes consumed by this number (1..10).
- `out_error`  out  1  encoding malformed; `out_value` is 0.

## Operation
- States: IDLE (await first byte), ACCUM (continuation bytes), HOLD (result presented).
- `in_ready` = 1 in IDLE and ACCUM, 0 in HOLD. Byte transfer = `in_valid && in_ready`.
- IDLE transfer: latch `in_signed`/`in_is64` (forced 0 if `USE_64B`=0), clear accumulator, count = 1, accumulate bits [6:0] at shift 0.
- Each transfer: acc |= byte[6:0] << (7*(count-1)). Bit 7 = 1 and not last allowed byte -> ACCUM; bit 7 = 0 -> finish.
- Max bytes N: 5 (32-bit), 10 (64-bit). Byte N with bit 7 = 1 -> finish with error.
- Final-byte checks when count = N: u32 bits[6:4] = 0; s32 bits[6:3] all equal; u64 bits[6:1] = 0; s64 byte is 0x00 or 0x7F. Violation -> error.
- Signed and byte bit 6 = 1 and total shift < 64 -> fill bits above the last group with 1s.
- Extension to 64: 32-bit signed sign-extends bit 31; 32-bit unsigned zero-extends.
- Finish: register `out_value`, `out_len` = count, `out_error`; -> HOLD. Error forces `out_value` = 0.
- HOLD: outputs stable until `out_valid && out_ready`; then -> IDLE.
- Bytes after an error-terminated number begin a new number; no resynchronisation.

## Timing
- Reset (async assert, any state): state IDLE, `in_ready` = 1 after deassertion, `out_valid` = 0, `out_value` = 0, `out_len` = 0, `out_error` = 0. Partial number discarded.
- Latency: `out_valid` rises the cycle after the final byte's transfer edge.
- Throughput: k-byte number occupies k transfer cycles + 1 HOLD cycle minimum; one bubble per number.
- `in_valid` low in ACCUM: stall, accumulator and count held, no timeout.
- `out_ready` may be high before `out_valid`; handshake completes on first cycle both high.
- `in_signed`/`in_is64` changes after the first byte have no effect.
- Accumulator is 64 bits; no shift exceeds 63 (10th group contributes bit 63 only).

## Test plan
- u32, bytes E5 8E 26 back-to-back -> after 3rd byte + 1 cycle: `out_value` = 0x0000_0000_0009_8765 (624485), `out_len` = 3, `out_error` = 0.
- s32, bytes C0 BB 78 -> `out_value` = 0xFFFF_FFFF_FFFE_1DC0 (-123456), `out_len` = 3.
- s64, byte 7F -> `out_value` = 0xFFFF_FFFF_FFFF_FFFF, `out_len` = 1; u64, 80×9 then 01 -> `out_value` = 0x8000_0000_0000_0000, `out_len` = 10.
- u32 errors: 80 80 80 80 10 -> `out_error` = 1, `out_value` = 0, `out_len` = 5; 80×5 -> error after 5th byte, `out_len` = 5, following byte 03 decodes as 3, len 1.
- Backpressure: u32 byte 2A with `out_ready` low 3 cycles -> `out_valid`/`out_value` = 42 held, `in_ready` = 0 throughout; on `out_ready` high -> `out_valid` drops next cycle, `in_ready` = 1.
- Reset low after 2 bytes of E5 8E 26 -> all outputs 0, `in_ready` = 1 after release; then 05 -> `out_value` = 5, `out_len` = 1.
